// File: rtl/rst_release_seq_pkg.sv
// Shared types for the domain reset release sequencer.
package rst_release_seq_pkg;

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    WAIT_ACK = 3'd1,
    DONE     = 3'd2,
    ERR      = 3'd3,
    ASSERT   = 3'd4
  } seq_state_e;

  localparam int unsigned ERR_DOM_W = 4;

endpackage

// File: rtl/rst_release_seq_if.sv
// Per-domain reset/acknowledge bundle plus sequencer status.
interface rst_release_seq_if #(
  parameter int unsigned N_DOM = 4
);
  import rst_release_seq_pkg::*;

  logic [N_DOM-1:0]     i_dom_ack;
  logic                 i_sw_req;
  logic [N_DOM-1:0]     o_dom_rst;
  logic                 o_done;
  logic                 o_busy;
  logic                 o_err;
  logic [ERR_DOM_W-1:0] o_err_dom;

  modport master (
    output i_dom_ack, i_sw_req,
    input  o_dom_rst, o_done, o_busy, o_err, o_err_dom
  );

  modport slave (
    input  i_dom_ack, i_sw_req,
    output o_dom_rst, o_done, o_busy, o_err, o_err_dom
  );

endinterface

// File: rtl/rst_release_seq_cnt.sv
// Loadable saturating up-counter with an optional terminal-count compare.
module rst_seq_cnt #(
  parameter int unsigned W     = 10,
  parameter int unsigned TC    = 0,
  parameter bit          TC_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = TC_EN && (cnt_q == W'(TC));

endmodule

// File: rtl/rst_release_seq.sv
// Releases downstream domain resets one at a time, waiting for each domain's
// ready acknowledge; supports ack timeout and software re-sequencing.
module rst_release_seq
  import rst_release_seq_pkg::*;
#(
  parameter int unsigned N_DOM       = 4,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              i_rst,
  rst_release_seq_if.slave  bus
);

  localparam int unsigned IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  seq_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_DOM-1:0]     dom_rst_q, dom_rst_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [ERR_DOM_W-1:0] err_dom_q, err_dom_d;

  logic set_ld, set_inc, set_tc;
  logic tmr_ld, tmr_inc, tmr_tc;

  rst_seq_cnt #(
    .W     (10),
    .TC    (SETTLE_CYC - 1),
    .TC_EN (1'b1)
  ) u_settle (
    .clk      (clk),
    .rst      (i_rst),
    .ld_i     (set_ld),
    .ld_val_i ('0),
    .inc_i    (set_inc),
    .tc_o     (set_tc)
  );

  // Compare is compiled out when the timeout is disabled; the timer then just saturates.
  rst_seq_cnt #(
    .W     (16),
    .TC    ((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1),
    .TC_EN (ACK_TIMEOUT != 0)
  ) u_timer (
    .clk      (clk),
    .rst      (i_rst),
    .ld_i     (tmr_ld),
    .ld_val_i ('0),
    .inc_i    (tmr_inc),
    .tc_o     (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dom_rst_d = dom_rst_q;
    done_d    = done_q;
    busy_d    = busy_q;
    err_d     = err_q;
    err_dom_d = err_dom_q;
    set_ld    = 1'b0;
    set_inc   = 1'b0;
    tmr_ld    = 1'b0;
    tmr_inc   = 1'b0;
    case (state_q)
      HOLD: begin
        set_inc = 1'b1;
        if (set_tc) begin
          dom_rst_d[idx_q] = 1'b0;
          tmr_ld           = 1'b1;
          state_d          = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.i_dom_ack[idx_q]) begin
          if (idx_q == IDX_W'(N_DOM - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            set_ld  = 1'b1;
            state_d = HOLD;
          end
        end else if (tmr_tc) begin
          state_d          = ERR;
          err_d            = 1'b1;
          err_dom_d        = ERR_DOM_W'(idx_q);
          dom_rst_d[idx_q] = 1'b1;
          busy_d           = 1'b0;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      DONE, ERR: begin
        if (bus.i_sw_req) begin
          state_d = ASSERT;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          idx_d   = IDX_W'(N_DOM - 1);
        end
      end
      ASSERT: begin
        // idx walks downward here, reasserting from the highest domain to domain 0.
        dom_rst_d[idx_q] = 1'b1;
        if (idx_q == '0) begin
          set_ld  = 1'b1;
          state_d = HOLD;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= HOLD;
      idx_q     <= '0;
      dom_rst_q <= '1;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
      err_q     <= 1'b0;
      err_dom_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dom_rst_q <= dom_rst_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      err_dom_q <= err_dom_d;
    end
  end

  assign bus.o_dom_rst = dom_rst_q;
  assign bus.o_done    = done_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_err     = err_q;
  assign bus.o_err_dom = err_dom_q;

endmodule
